// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Front end of the MIPS-32 core. Owns the word-addressed fetch PC, issues
//   one outstanding request at a time to instruction memory over a req/ack
//   handshake, buffers fetched words in a small FIFO and presents them to the
//   decode stage over valid/ready. A redirect from downstream flushes the
//   FIFO and any in-flight request.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr      registered memory request and word address
//   imem_ack/imem_rdata     request accepted, instruction word same cycle
//   inst_valid/inst_ready   decode handshake (head consumed on both high)
//   inst_data/inst_pc       head instruction and its word PC (0 when empty)
//   inst_link               inst_pc + 1 (0 when empty)
//   redirect_valid/_target  control-flow change and new fetch PC
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic [31:0] inst_link,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t             state;
   logic [31:0]        fetch_pc;
   logic [31:0]        fifo_pc   [FIFO_DEPTH];
   logic [31:0]        fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;

   logic               not_empty;
   logic               pop;
   logic               push;
   logic [CNT_W:0]     count_after;
   logic               space_next;

   always_comb begin
      not_empty   = (count != '0);
      pop         = not_empty && inst_ready;
      push        = (state == REQ) && imem_ack && !redirect_valid;
      // Occupancy once this cycle's push and any pop have landed; decides
      // whether the next back-to-back request may be issued.
      count_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
      space_next  = (count_after < (CNT_W+1)'(FIFO_DEPTH));
   end

   always_comb begin
      inst_valid = not_empty;
      inst_data  = '0;
      inst_pc    = '0;
      inst_link  = '0;
      if (not_empty) begin
         inst_data = fifo_data[rd_ptr];
         inst_pc   = fifo_pc[rd_ptr];
         inst_link = fifo_pc[rd_ptr] + 32'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
      end else if (redirect_valid) begin
         // Buffered entries are discarded; an outstanding request must still
         // be drained, so REQ without ack moves to FLUSH with addr held.
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         fetch_pc <= redirect_target;
         unique case (state)
            IDLE: state <= IDLE;
            REQ: begin
               if (imem_ack) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end else begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (imem_ack) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_data[wr_ptr] <= imem_rdata;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);

         unique case (state)
            IDLE: begin
               if (count < CNT_W'(FIFO_DEPTH)) begin
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  fetch_pc <= fetch_pc + 32'd1;
                  if (space_next) begin
                     imem_addr <= fetch_pc + 32'd1;
                  end else begin
                     imem_req <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            FLUSH: begin
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               imem_req <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
